ram_burst_reader: RTL and testbench

- Read-side sequencer for the team's inferred single-port RAM. That RAM registers its address every clock and returns ram[addr_reg] combinationally.
- On a start command, walks a contiguous (wrapping) address range and issues one read per cycle.
- Absorbs the RAM's one-cycle read latency and streams words out on a valid/ready interface with a last marker.
- Sits between the RAM and any consumer (O_BUF/O_BUFT output stage, checker, UART-style serialiser); the existing design already drives the write side.

---
 rtl/ram_burst_reader.sv | 195 +++++++++++++++++++
 tb/tb_ram_burst_reader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
// Burst read sequencer for the single-port RAM: issues one read per cycle under credit and streams words out with a last marker.
// Optional even-parity output m_parity is enabled by defining RAM_BURST_READER_PARITY_EN.
module ram_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
`ifdef RAM_BURST_READER_PARITY_EN
    ,
    output logic                  m_parity
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [LW-1:0]           issue_cnt_q, issue_cnt_d;
    logic [LW-1:0]           beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic                    s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] buf_dat_q, buf_dat_d;
    logic [FIFO_DEPTH-1:0]   buf_last_q, buf_last_d;
`ifdef RAM_BURST_READER_PARITY_EN
    logic [FIFO_DEPTH-1:0]   buf_par_q, buf_par_d;
`endif

    logic [CW:0] occ;
    logic        credit_ok;
    logic        push;
    logic        pop;

    assign m_valid  = (cnt_q != '0);
    assign m_data   = buf_dat_q[rd_ptr_q];
    assign m_last   = m_valid & buf_last_q[rd_ptr_q];
    assign ram_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef RAM_BURST_READER_PARITY_EN
    assign m_parity = buf_par_q[rd_ptr_q];
`endif

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        addr_d      = addr_q;
        s1_vld_d    = 1'b0;
        s1_last_d   = 1'b0;
        s2_vld_d    = s1_vld_q;
        s2_last_d   = s1_last_q;
        busy_d      = busy_q && !done_q;
        done_d      = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        buf_dat_d   = buf_dat_q;
        buf_last_d  = buf_last_q;
`ifdef RAM_BURST_READER_PARITY_EN
        buf_par_d   = buf_par_q;
`endif

        // Credit covers buffered words plus reads still in the address and RAM register stages.
        occ       = {1'b0, cnt_q} + (CW+1)'(s1_vld_q) + (CW+1)'(s2_vld_q);
        credit_ok = (occ < (CW+1)'(FIFO_DEPTH));
        push      = s2_vld_q;
        pop       = m_valid && m_ready;

        if (pop && beat_cnt_q != '0) begin
            beat_cnt_d = beat_cnt_q - LW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    if (length != '0) begin
                        // Loading the address is the first issued read.
                        state_d     = READ;
                        addr_d      = start_addr;
                        issue_cnt_d = length - LW'(1);
                        beat_cnt_d  = length;
                        s1_vld_d    = 1'b1;
                        s1_last_d   = (length == LW'(1));
                        busy_d      = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (issue_cnt_q == '0) begin
                    state_d = DRAIN;
                end else if (credit_ok) begin
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    issue_cnt_d = issue_cnt_q - LW'(1);
                    s1_vld_d    = 1'b1;
                    s1_last_d   = (issue_cnt_q == LW'(1));
                end
            end
            DRAIN: begin
                if (pop && beat_cnt_q == LW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            buf_dat_d[wr_ptr_q]  = ram_q;
            buf_last_d[wr_ptr_q] = s2_last_q;
`ifdef RAM_BURST_READER_PARITY_EN
            buf_par_d[wr_ptr_q]  = ^ram_q;
`endif
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            addr_q      <= '0;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            buf_dat_q   <= '0;
            buf_last_q  <= '0;
`ifdef RAM_BURST_READER_PARITY_EN
            buf_par_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            addr_q      <= addr_d;
            s1_vld_q    <= s1_vld_d;
            s1_last_q   <= s1_last_d;
            s2_vld_q    <= s2_vld_d;
            s2_last_q   <= s2_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            buf_dat_q   <= buf_dat_d;
            buf_last_q  <= buf_last_d;
`ifdef RAM_BURST_READER_PARITY_EN
            buf_par_q   <= buf_par_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader: vector table, corner-case sequences and randomized bursts against a queue model.
module tb_ram_burst_reader;

    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [5:0] start_addr = '0;
    logic [6:0] length = '0;
    logic       busy, done;
    logic [5:0] ram_addr;
    logic [7:0] ram_q;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_last;
`ifdef RAM_BURST_READER_PARITY_EN
    logic       m_parity;
`endif

    ram_burst_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_q(ram_q),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef RAM_BURST_READER_PARITY_EN
        , .m_parity(m_parity)
`endif
    );

    always #5 clk = ~clk;

    // RAM model: address registered every clock, data read combinationally.
    logic [7:0] mem [DEPTH];
    logic [5:0] addr_reg = '0;
    always @(posedge clk) addr_reg <= ram_addr;
    assign ram_q = mem[addr_reg];

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] got_d[$];
    bit         got_l[$];
    bit         got_p[$];
    int first_valid_cyc, first_beat_cyc, last_beat_cyc, done_cyc;

    typedef struct {
        logic [5:0] sa;
        logic [6:0] len;
        int         mode;
        bit         inj;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: random; 3: ready low for 30 cycles
    task automatic run_burst(input logic [5:0] sa, input logic [6:0] len, input int mode, input bit inj);
        int cyc;
        bit stalled;
        bit finished;
        logic [7:0] prev_d;
        logic prev_l;
        logic [5:0] stall_addr;
        got_d.delete();
        got_l.delete();
        got_p.delete();
        first_valid_cyc = -1;
        first_beat_cyc = -1;
        last_beat_cyc = -1;
        done_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        start_addr = sa;
        length = len;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        stalled = 1'b0;
        finished = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        while (!finished && cyc < 3000) begin
            if (inj && cyc == 3) begin
                start = 1'b1;
                start_addr = sa + 6'd9;
                length = 7'd5;
            end else begin
                start = 1'b0;
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stalled) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(prev_d));
                check("hold_last", 32'(m_last), 32'(prev_l));
            end
            if (mode == 3 && cyc == 20) begin
                stall_addr = sa + 6'd3;
                check("credit_stall_addr", 32'(ram_addr), 32'(stall_addr));
            end
            if (done) begin
                done_cyc = cyc;
                check("busy_with_done", 32'(busy), 32'd1);
                finished = 1'b1;
            end else begin
                case (mode)
                    0: m_ready = 1'b1;
                    1: m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                    2: m_ready = 1'($urandom_range(0, 1));
                    default: m_ready = (cyc >= 30);
                endcase
                if (m_valid && m_ready) begin
                    got_d.push_back(m_data);
                    got_l.push_back(m_last);
`ifdef RAM_BURST_READER_PARITY_EN
                    got_p.push_back(m_parity);
`endif
                    if (first_beat_cyc < 0) first_beat_cyc = cyc;
                    last_beat_cyc = cyc;
                end
                stalled = m_valid && !m_ready;
                prev_d = m_data;
                prev_l = m_last;
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(finished), 32'd1);
        m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("idle_valid", 32'(m_valid), 32'd0);
    endtask

    // Reference: word i of the burst is mem[(sa+i) mod 64], last flag only on word len-1.
    task automatic compare_burst(input logic [5:0] sa, input logic [6:0] len);
        logic [5:0] a;
        check("beat_count", 32'(got_d.size()), 32'(len));
        for (int i = 0; i < got_d.size() && i < int'(len); i++) begin
            a = sa + i[5:0];
            check($sformatf("beat_data[%0d]", i), 32'(got_d[i]), 32'(mem[a]));
            check($sformatf("beat_last[%0d]", i), 32'(got_l[i]), 32'(i == int'(len) - 1));
`ifdef RAM_BURST_READER_PARITY_EN
            check($sformatf("beat_parity[%0d]", i), 32'(got_p[i]), 32'(^mem[a]));
`endif
        end
        check("first_valid_latency", 32'(first_valid_cyc), 32'd2);
        check("done_after_last", 32'(done_cyc), 32'(last_beat_cyc + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int beats;
        int spurious;
        logic [5:0] rsa;
        logic [6:0] rlen;

        vecs[0] = '{6'd5,  7'd4,  0, 1'b0, 8'h15, 8'h18};
        vecs[1] = '{6'd0,  7'd8,  1, 1'b1, 8'h10, 8'h17};
        vecs[2] = '{6'd62, 7'd64, 0, 1'b0, 8'h4E, 8'h4D};
        vecs[3] = '{6'd63, 7'd2,  1, 1'b0, 8'h4F, 8'h10};
        vecs[4] = '{6'd10, 7'd1,  0, 1'b0, 8'h1A, 8'h1A};
        vecs[5] = '{6'd20, 7'd7,  3, 1'b0, 8'h24, 8'h2A};

        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 16);

        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
`ifdef RAM_BURST_READER_PARITY_EN
        check("rst_m_parity", 32'(m_parity), 32'd0);
`endif
        rst = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_burst(vecs[v].sa, vecs[v].len, vecs[v].mode, vecs[v].inj);
            compare_burst(vecs[v].sa, vecs[v].len);
            if (got_d.size() > 0) begin
                check("vec_first", 32'(got_d[0]), 32'(vecs[v].exp_first));
                check("vec_last", 32'(got_d[got_d.size()-1]), 32'(vecs[v].exp_last));
            end
            if (vecs[v].mode == 0)
                check("no_bubbles", 32'(last_beat_cyc - first_beat_cyc), 32'(int'(vecs[v].len) - 1));
        end

        // Zero-length command
        @(negedge clk);
        start = 1'b1;
        start_addr = 6'd7;
        length = 7'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("zero_len_done", 32'(done), 32'd1);
        check("zero_len_busy", 32'(busy), 32'd0);
        check("zero_len_valid", 32'(m_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("zero_len_done_fall", 32'(done), 32'd0);
        check("zero_len_busy_after", 32'(busy), 32'd0);
        check("zero_len_valid_after", 32'(m_valid), 32'd0);

        // Reset after 3 of 10 beats
        start = 1'b1;
        start_addr = 6'd30;
        length = 7'd10;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        m_ready = 1'b1;
        beats = 0;
        for (int c = 0; c < 50 && beats < 3; c++) begin
            if (m_valid) beats++;
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_mid_beats_seen", 32'(beats), 32'd3);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_valid", 32'(m_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        rst = 1'b1;
        spurious = 0;
        for (int c = 0; c < 20; c++) begin
            if (m_valid || done || busy) spurious++;
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_mid_quiet", 32'(spurious), 32'd0);
        m_ready = 1'b0;
        run_burst(6'd30, 7'd10, 0, 1'b0);
        compare_burst(6'd30, 7'd10);

`ifdef RAM_BURST_READER_PARITY_EN
        mem[0] = 8'h07;
        mem[1] = 8'h03;
        run_burst(6'd0, 7'd2, 0, 1'b0);
        if (got_p.size() == 2) begin
            check("parity_07", 32'(got_p[0]), 32'd1);
            check("parity_03", 32'(got_p[1]), 32'd0);
        end else begin
            check("parity_beats", 32'(got_p.size()), 32'd2);
        end
`endif

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
            rsa = 6'($urandom_range(0, 63));
            rlen = (r % 5 == 0) ? 7'd64 : 7'($urandom_range(1, 64));
            run_burst(rsa, rlen, 2, (r % 3 == 0));
            compare_burst(rsa, rlen);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
